// File: rtl/immediate_extension_pipe.sv
// immediate_extension_pipe: extends an N-bit immediate to M bits (sign, zero,
// shifted branch offset, load-upper) behind a registered output stage with a
// one-entry skid buffer so valid/ready sustains one transfer per cycle.
module immediate_extension_pipe #(
  parameter int unsigned N     = 16,
  parameter int unsigned M     = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] imm_in,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] imm_out,
  output logic         ovf
);

  // Width of the sign-extended value before branch-mode truncation.
  localparam int unsigned W = M + SHIFT;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_UPPER  = 2'b11;

  logic [W-1:0] sx_wide;
  logic [W-1:0] br_wide;
  logic [M-1:0] sx_val;
  logic [M-1:0] zx_val;
  logic [M-1:0] up_val;
  logic         br_lost;
  logic [M-1:0] ext_data;
  logic         ext_ovf;

  logic [M-1:0] sk_data;
  logic         sk_ovf;
  logic         sk_valid;

  logic         accept;
  logic         drain;

  // Candidate results for every mode, built from the raw field.
  always_comb begin
    sx_wide            = {W{imm_in[N-1]}};
    sx_wide[N-1:0]     = imm_in;
    br_wide            = sx_wide << SHIFT;
    sx_val             = {M{imm_in[N-1]}};
    sx_val[N-1:0]      = imm_in;
    zx_val             = '0;
    zx_val[N-1:0]      = imm_in;
    up_val             = '0;
    up_val[M-1:M-N]    = imm_in;
  end

  // Branch overflow: the bits dropped by truncation must all repeat the kept sign bit.
  generate
    if (SHIFT > 0) begin : g_br_ovf
      assign br_lost = (br_wide[W-1:M] != {SHIFT{br_wide[M-1]}});
    end else begin : g_br_no_ovf
      assign br_lost = 1'b0;
    end
  endgenerate

  // Select the extension result and its overflow flag by mode.
  always_comb begin
    ext_data = sx_val;
    ext_ovf  = 1'b0;
    case (mode)
      MODE_SIGN:   ext_data = sx_val;
      MODE_ZERO:   ext_data = zx_val;
      MODE_BRANCH: begin
        ext_data = br_wide[M-1:0];
        ext_ovf  = br_lost;
      end
      MODE_UPPER:  ext_data = up_val;
      default:     ext_data = sx_val;
    endcase
  end

  // Ready depends only on held state (and reset), never on out_ready.
  assign in_ready = !sk_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Output register and skid buffer; skid always drains before new input is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      imm_out   <= '0;
      ovf       <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_ovf    <= 1'b0;
    end else if (sk_valid) begin
      if (drain) begin
        imm_out  <= sk_data;
        ovf      <= sk_ovf;
        sk_valid <= 1'b0;
      end
    end else if (!out_valid || drain) begin
      out_valid <= accept;
      if (accept) begin
        imm_out <= ext_data;
        ovf     <= ext_ovf;
      end
    end else if (accept) begin
      sk_data  <= ext_data;
      sk_ovf   <= ext_ovf;
      sk_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_immediate_extension_pipe.sv
// Self-checking bench: three parameterisations driven in lockstep, a queue
// scoreboard per instance, plus directed checks for latency, stalls and reset.
module tb_immediate_extension_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] imm;
  logic [1:0]  mode;

  logic        ir0, ov0, of0;
  logic [31:0] io0;
  logic        ir1, ov1, of1;
  logic [25:0] io1;
  logic        ir2, ov2, of2;
  logic [16:0] io2;

  int errors = 0;
  int checks = 0;
  int n_out0 = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];
  logic [32:0] e0, e1, e2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  immediate_extension_pipe #(.N(16), .M(32), .SHIFT(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .imm_in(imm),
    .mode(mode), .out_valid(ov0), .out_ready(out_ready), .imm_out(io0), .ovf(of0));

  immediate_extension_pipe #(.N(12), .M(26), .SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .imm_in(imm[11:0]),
    .mode(mode), .out_valid(ov1), .out_ready(out_ready), .imm_out(io1), .ovf(of1));

  immediate_extension_pipe #(.N(16), .M(17), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .imm_in(imm),
    .mode(mode), .out_valid(ov2), .out_ready(out_ready), .imm_out(io2), .ovf(of2));

  // Arithmetic reference: {ovf, result} for a given geometry.
  function automatic logic [32:0] model(input int n, input int m, input int sh,
                                        input logic [15:0] im, input logic [1:0] md);
    longint u, sv, shv, r, kr, mask;
    logic   o;
    u    = longint'(im) & ((64'sd1 <<< n) - 64'sd1);
    sv   = im[n-1] ? (u - (64'sd1 <<< n)) : u;
    mask = (64'sd1 <<< m) - 64'sd1;
    o    = 1'b0;
    case (md)
      2'b00:   r = sv & mask;
      2'b01:   r = u;
      2'b10: begin
        shv = sv <<< sh;
        r   = shv & mask;
        kr  = r[m-1] ? (r - (64'sd1 <<< m)) : r;
        o   = (kr != shv);
      end
      default: r = (u <<< (m - n)) & mask;
    endcase
    return {o, r[31:0]};
  endfunction

  task automatic push_if_accepted();
    if (in_valid && ir0) q0.push_back(model(16, 32, 2, imm, mode));
    if (in_valid && ir1) q1.push_back(model(12, 26, 2, imm, mode));
    if (in_valid && ir2) q2.push_back(model(16, 17, 2, imm, mode));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transfer on each instance must match the oldest pending item.
  always @(negedge clk) begin
    if (!rst && ov0 && out_ready) begin
      checks++;
      n_out0++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_extra got=%h ovf=%b required=no transfer", io0, of0);
      end else begin
        e0 = q0.pop_front();
        if ({of0, io0} !== e0) begin
          errors++;
          $display("FAIL sb0 got=%h ovf=%b required=%h ovf=%b", io0, of0, e0[31:0], e0[32]);
        end
      end
    end
    if (!rst && ov1 && out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_extra got=%h ovf=%b required=no transfer", io1, of1);
      end else begin
        e1 = q1.pop_front();
        if ({of1, io1} !== {e1[32], e1[25:0]}) begin
          errors++;
          $display("FAIL sb1 got=%h ovf=%b required=%h ovf=%b", io1, of1, e1[25:0], e1[32]);
        end
      end
    end
    if (!rst && ov2 && out_ready) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_extra got=%h ovf=%b required=no transfer", io2, of2);
      end else begin
        e2 = q2.pop_front();
        if ({of2, io2} !== {e2[32], e2[16:0]}) begin
          errors++;
          $display("FAIL sb2 got=%h ovf=%b required=%h ovf=%b", io2, of2, e2[16:0], e2[32]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; imm = '0; mode = 2'b00;
    tick();
    tick();
    checks++;
    if ({ov0, ov1, ov2, of0, of1, of2, ir0, ir1, ir2} !== 9'b0 || io0 !== 32'h0 ||
        io1 !== 26'h0 || io2 !== 17'h0) begin
      errors++;
      $display("FAIL reset_state valid=%b%b%b ovf=%b%b%b ready=%b%b%b data=%h/%h/%h required=all 0",
               ov0, ov1, ov2, of0, of1, of2, ir0, ir1, ir2, io0, io1, io2);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ir0, ir1, ir2} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b%b%b required=111", ir0, ir1, ir2);
    end
    tick();
  endtask

  task automatic test_vectors();
    logic [15:0] vi [6];
    logic [1:0]  vm [6];
    logic [31:0] ve [6];
    vi = '{16'h7FFF, 16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
    vm = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
    ve = '{32'h00007FFF, 32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; imm = vi[i]; mode = vm[i];
      push_if_accepted();
      tick();
      checks++;
      if (ov0 !== 1'b1 || io0 !== ve[i] || of0 !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d valid=%b data=%h ovf=%b required valid=1 data=%h ovf=0",
                 i, ov0, io0, of0, ve[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL vec_drain_empty valid=%b required=0", ov0);
    end
  endtask

  task automatic test_params();
    logic [15:0] vi [6];
    logic [1:0]  vm [6];
    logic [25:0] x1 [3];
    logic [17:0] x2 [3];
    vi = '{16'h0800, 16'h0800, 16'h0800, 16'h4000, 16'h1FFF, 16'hF000};
    vm = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    x1 = '{26'h3FFF800, 26'h0000800, 26'h2000000};
    x2 = '{{1'b1, 17'h10000}, {1'b0, 17'h07FFC}, {1'b0, 17'h1C000}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; imm = vi[i]; mode = vm[i];
      push_if_accepted();
      tick();
      checks++;
      if (i < 3) begin
        if (ov1 !== 1'b1 || io1 !== x1[i] || of1 !== 1'b0) begin
          errors++;
          $display("FAIL n12_m26_%0d valid=%b data=%h ovf=%b required data=%h ovf=0",
                   i, ov1, io1, of1, x1[i]);
        end
      end else begin
        if (ov2 !== 1'b1 || {of2, io2} !== x2[i-3]) begin
          errors++;
          $display("FAIL m17_ovf_%0d valid=%b data=%h ovf=%b required data=%h ovf=%b",
                   i, ov2, io2, of2, x2[i-3][16:0], x2[i-3][17]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    logic [15:0] vi [4];
    logic [1:0]  vm [4];
    int idx;
    int start_out;
    vi = '{16'h1111, 16'h8222, 16'h9333, 16'h4444};
    vm = '{2'b00, 2'b01, 2'b10, 2'b11};
    idx = 0;
    start_out = n_out0;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (idx < 4);
      imm       = vi[idx % 4];
      mode      = vm[idx % 4];
      out_ready = !(c >= 1 && c <= 3);
      if (in_valid && ir0) begin
        push_if_accepted();
        idx++;
      end
      tick();
      if (c <= 3) begin
        checks++;
        if (ov0 !== 1'b1 || io0 !== 32'h00001111) begin
          errors++;
          $display("FAIL bp_hold_a c=%0d valid=%b data=%h required valid=1 data=00001111",
                   c, ov0, io0);
        end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (ir0 !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_low c=%0d got=%b required=0", c, ir0);
        end
      end
      if (c == 4) begin
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b1 || io0 !== 32'h00008222) begin
          errors++;
          $display("FAIL bp_release ready=%b valid=%b data=%h required ready=1 valid=1 data=00008222",
                   ir0, ov0, io0);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out0 - start_out != 4 || q0.size() != 0 || idx != 4) begin
      errors++;
      $display("FAIL bp_count outputs=%0d pending=%0d accepted=%0d required 4/0/4",
               n_out0 - start_out, q0.size(), idx);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h5555; mode = 2'b00;
    push_if_accepted();
    tick();
    imm = 16'h6666; mode = 2'b01;
    push_if_accepted();
    tick();
    in_valid = 1'b0;
    checks++;
    if (ir0 !== 1'b0 || ov0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_full ready=%b valid=%b required ready=0 valid=1", ir0, ov0);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({ov0, ov1, ov2, of0, of1, of2} !== 6'b0 || io0 !== 32'h0 || io1 !== 26'h0 ||
        io2 !== 17'h0 || {ir0, ir1, ir2} !== 3'b111) begin
      errors++;
      $display("FAIL rst_mid_state valid=%b%b%b ovf=%b%b%b ready=%b%b%b data=%h required valid/ovf/data 0 ready 1",
               ov0, ov1, ov2, of0, of1, of2, ir0, ir1, ir2, io0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ov0, ov1, ov2} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_ghost cycle=%0d valid=%b%b%b required=000", i, ov0, ov1, ov2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_params();
    test_back_pressure();
    test_reset_mid();
    test_vectors();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
